// File: rtl/n64adv2_igr_decoder.sv
// n64adv2_igr_decoder: N64 controller poll decoder producing button edge flags, held-combo IGR reset/OSD requests and a lost-controller watchdog.
//
// Ports:
//   CTRL_CLK, CTRL_RST          controller clock, synchronous active-high reset
//   ctrl_data_i/_valid_i        captured 32-bit controller word and its one-cycle strobe
//   use_igr_i                   enables the combo FSMs
//   btn_state_o/_pressed_o      last polled buttons and their rising edges
//   btn_update_o                one-cycle pulse after every accepted poll
//   igr_reset_o, igr_osd_o      one-cycle combo requests
//   ctrl_lost_o                 high while the watchdog has expired
// Define IGR_OSD_COMBO_EN to build the OSD combo FSM; otherwise igr_osd_o is tied low.
module n64adv2_igr_decoder #(
  parameter logic [15:0] IGR_RESET_COMBO = 16'h080F,
  parameter logic [15:0] IGR_OSD_COMBO   = 16'h8C40,
  parameter logic [7:0]  HOLD_POLLS      = 8'd30,
  parameter int          TIMEOUT_W       = 20
) (
  input  logic        CTRL_CLK,
  input  logic        CTRL_RST,
  input  logic [31:0] ctrl_data_i,
  input  logic        ctrl_data_valid_i,
  input  logic        use_igr_i,
  output logic [15:0] btn_state_o,
  output logic [15:0] btn_pressed_o,
  output logic        btn_update_o,
  output logic        igr_reset_o,
  output logic        igr_osd_o,
  output logic        ctrl_lost_o
);
  typedef enum logic [1:0] {IDLE, ARM, FIRE, RELEASE} state_t;

  // Returns {next_state, next_hold_cnt} for one combo FSM.
  function automatic logic [9:0] step(input state_t s, input logic [7:0] c, input logic v, input logic m);
    logic [7:0] n;
    n = c + {7'd0, c != 8'hFF};
    case (s)
      IDLE:    return (v && m) ? {(HOLD_POLLS == 8'd1) ? FIRE : ARM, 8'd1} : {IDLE, c};
      ARM:     return !v ? {ARM, c} : m ? {(n >= HOLD_POLLS) ? FIRE : ARM, n} : {IDLE, 8'd0};
      FIRE:    return {RELEASE, c};
      default: return (v && !m) ? {IDLE, 8'd0} : {RELEASE, c};
    endcase
  endfunction

  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic lost_d, clear_fsm;
  state_t rst_st_q, rst_st_d;
  logic [7:0] rst_cnt_q, rst_cnt_d;
  logic [9:0] rst_nx;

  // Valid strobe wins over a same-cycle expiry; the counter sticks at all-ones.
  assign wd_d = ctrl_data_valid_i ? '0 : wd_q + {{(TIMEOUT_W-1){1'b0}}, ~&wd_q};
  assign lost_d = &wd_d;
  assign clear_fsm = ~use_igr_i | lost_d;
  assign rst_nx = step(rst_st_q, rst_cnt_q, ctrl_data_valid_i, ctrl_data_i[15:0] == IGR_RESET_COMBO);
  assign rst_st_d = clear_fsm ? IDLE : state_t'(rst_nx[9:8]);
  assign rst_cnt_d = clear_fsm ? 8'd0 : rst_nx[7:0];

  always_ff @(posedge CTRL_CLK) begin
    if (CTRL_RST) begin
      wd_q <= '0;
      ctrl_lost_o <= 1'b0;
      btn_state_o <= '0;
      btn_pressed_o <= '0;
      btn_update_o <= 1'b0;
      rst_st_q <= IDLE;
      rst_cnt_q <= '0;
      igr_reset_o <= 1'b0;
    end else begin
      wd_q <= wd_d;
      ctrl_lost_o <= lost_d;
      btn_update_o <= ctrl_data_valid_i;
      if (lost_d) begin
        btn_state_o <= '0;
        btn_pressed_o <= '0;
      end else if (ctrl_data_valid_i) begin
        btn_state_o <= ctrl_data_i[15:0];
        btn_pressed_o <= ctrl_data_i[15:0] & ~btn_state_o;
      end
      rst_st_q <= rst_st_d;
      rst_cnt_q <= rst_cnt_d;
      igr_reset_o <= (rst_st_q == FIRE) & use_igr_i;
    end
  end

`ifdef IGR_OSD_COMBO_EN
  state_t osd_st_q, osd_st_d;
  logic [7:0] osd_cnt_q, osd_cnt_d;
  logic [9:0] osd_nx;

  assign osd_nx = step(osd_st_q, osd_cnt_q, ctrl_data_valid_i, ctrl_data_i[15:0] == IGR_OSD_COMBO);
  // When both combos would fire on the same poll, reset wins and OSD is swallowed.
  assign osd_st_d = clear_fsm ? IDLE :
                    (state_t'(osd_nx[9:8]) == FIRE && rst_st_d == FIRE) ? RELEASE : state_t'(osd_nx[9:8]);
  assign osd_cnt_d = clear_fsm ? 8'd0 : osd_nx[7:0];

  always_ff @(posedge CTRL_CLK) begin
    if (CTRL_RST) begin
      osd_st_q <= IDLE;
      osd_cnt_q <= '0;
      igr_osd_o <= 1'b0;
    end else begin
      osd_st_q <= osd_st_d;
      osd_cnt_q <= osd_cnt_d;
      igr_osd_o <= (osd_st_q == FIRE) & use_igr_i;
    end
  end
`else
  assign igr_osd_o = 1'b0;
`endif
endmodule

// File: tb/tb_n64adv2_igr_decoder.sv
// tb_n64adv2_igr_decoder: directed self-checking bench for n64adv2_igr_decoder.
module tb_n64adv2_igr_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] data = '0;
  logic valid = 1'b0;
  logic use_igr = 1'b1;
  logic [15:0] btn_state, btn_pressed;
  logic btn_update, igr_reset, igr_osd, ctrl_lost;
  int total = 0;
  int bad = 0;
  int rst_pulses = 0;
  int osd_pulses = 0;

  n64adv2_igr_decoder #(.TIMEOUT_W(6)) dut (
    .CTRL_CLK(clk), .CTRL_RST(rst), .ctrl_data_i(data), .ctrl_data_valid_i(valid),
    .use_igr_i(use_igr), .btn_state_o(btn_state), .btn_pressed_o(btn_pressed),
    .btn_update_o(btn_update), .igr_reset_o(igr_reset), .igr_osd_o(igr_osd),
    .ctrl_lost_o(ctrl_lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (igr_reset) rst_pulses++;
    if (igr_osd) osd_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poll(input logic [15:0] d);
    @(negedge clk);
    data = {16'hA5C3, d};
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic hold(input int n, input logic [15:0] d);
    for (int i = 0; i < n; i++) poll(d);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check("rst_state", {16'd0, btn_state}, 32'd0);
    check("rst_pressed", {16'd0, btn_pressed}, 32'd0);
    check("rst_update", {31'd0, btn_update}, 32'd0);
    check("rst_igr", {31'd0, igr_reset}, 32'd0);
    check("rst_osd", {31'd0, igr_osd}, 32'd0);
    check("rst_lost", {31'd0, ctrl_lost}, 32'd0);
    rst = 1'b0;

    poll(16'h080F);
    check("first_pressed", {16'd0, btn_pressed}, 32'h080F);
    check("first_state", {16'd0, btn_state}, 32'h080F);
    check("first_update", {31'd0, btn_update}, 32'd1);
    @(negedge clk);
    check("update_drop", {31'd0, btn_update}, 32'd0);
    hold(28, 16'h080F);
    check("held_pressed", {16'd0, btn_pressed}, 32'd0);
    poll(16'h080F);
    check("igr_edge1", {31'd0, igr_reset}, 32'd0);
    @(negedge clk);
    check("igr_edge2", {31'd0, igr_reset}, 32'd1);
    @(negedge clk);
    check("igr_width", {31'd0, igr_reset}, 32'd0);
    hold(50, 16'h080F);
    check("no_refire", rst_pulses, 32'd1);

    poll(16'h0000);
    hold(29, 16'h080F);
    poll(16'h0000);
    hold(29, 16'h080F);
    poll(16'h0000);
    repeat (3) @(negedge clk);
    check("broken_hold", rst_pulses, 32'd1);

    use_igr = 1'b0;
    poll(16'h080F);
    check("noigr_pressed", {16'd0, btn_pressed}, 32'h080F);
    hold(39, 16'h080F);
    poll(16'h0000);
    repeat (3) @(negedge clk);
    check("noigr_pulse", rst_pulses, 32'd1);
    use_igr = 1'b1;

    hold(40, 16'h081F);
    poll(16'h0000);
    repeat (3) @(negedge clk);
    check("extra_btn", rst_pulses, 32'd1);
    hold(30, 16'h080F);
    repeat (3) @(negedge clk);
    check("repress", rst_pulses, 32'd2);

    poll(16'h0000);
    base = osd_pulses;
    hold(30, 16'h8C40);
    repeat (3) @(negedge clk);
`ifdef IGR_OSD_COMBO_EN
    check("osd_fire", osd_pulses - base, 32'd1);
`else
    check("osd_off", osd_pulses - base, 32'd0);
`endif
    check("osd_no_reset", rst_pulses, 32'd2);
    poll(16'h0000);
    base = osd_pulses;
    hold(30, 16'h8C40);
    rst = 1'b1;
    @(negedge clk);
    check("rstfire_osd", {31'd0, igr_osd}, 32'd0);
    check("rstfire_state", {16'd0, btn_state}, 32'd0);
    check("rstfire_pressed", {16'd0, btn_pressed}, 32'd0);
    check("rstfire_lost", {31'd0, ctrl_lost}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstfire_count", osd_pulses - base, 32'd0);

    poll(16'h0003);
    repeat (62) @(negedge clk);
    check("wd_before", {31'd0, ctrl_lost}, 32'd0);
    check("wd_before_state", {16'd0, btn_state}, 32'h0003);
    @(negedge clk);
    check("wd_lost", {31'd0, ctrl_lost}, 32'd1);
    check("wd_state", {16'd0, btn_state}, 32'd0);
    poll(16'h0001);
    check("wd_recover", {31'd0, ctrl_lost}, 32'd0);
    check("wd_pressed", {16'd0, btn_pressed}, 32'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/n64adv2_igr_decoder.md
# n64adv2_igr_decoder

Downstream consumer of the controller-sniffing stage, in the CTRL_CLK domain. Takes each captured 32-bit N64 controller word plus its one-cycle valid strobe, and derives three things: per-poll button edge flags, an in-game-routine (IGR) reset request, and an optional OSD-menu toggle request. Each request fires only after its button combo has been held for a configured number of consecutive polls. A watchdog detects a lost controller stream and clears all state.

## Interface
Parameters:
- IGR_RESET_COMBO, 16'h080F, exact button pattern (A+B+Z+St+R) that requests a console reset
- IGR_OSD_COMBO, 16'h8C40, exact button pattern (Dl+L+R+Cr) that toggles the OSD menu
- HOLD_POLLS, 8'd30, consecutive matching polls required before a request fires (legal range 1..255)
- TIMEOUT_W, 20, width of the lost-controller watchdog counter

Ports:
- CTRL_CLK  in  1  controller clock (4 MHz)
- CTRL_RST  in  1  synchronous, active-high reset
- ctrl_data_i  in  32  controller word: [7:0] A,B,Z,St,Du,Dd,Dl,Dr; [15:8] JoyRst,0,L,R,Cu,Cd,Cl,Cr; [23:16] X; [31:24] Y
- ctrl_data_valid_i  in  1  one-cycle strobe; ctrl_data_i is valid on this cycle
- use_igr_i  in  1  IGR enable, quasi-static and already synchronised to CTRL_CLK
- btn_state_o  out  16  registered copy of ctrl_data_i[15:0] from the last valid poll
- btn_pressed_o  out  16  rising-edge flags of the last poll (new & ~old); held until the next poll
- btn_update_o  out  1  one-cycle pulse; btn_state_o and btn_pressed_o have just changed
- igr_reset_o  out  1  one-cycle reset request to the reset driver
- igr_osd_o  out  1  one-cycle OSD toggle request
- ctrl_lost_o  out  1  high while the watchdog is expired

## Operation
- Button match: exact equality of ctrl_data_i[15:0] against the combo. Bits [31:16] are ignored. Any extra pressed button counts as a non-match.
- Each combo (reset, OSD) has its own FSM with states IDLE, ARM, FIRE, RELEASE:
  - IDLE: on a valid poll with a match -> ARM, hold_cnt=1. If HOLD_POLLS==1, go directly -> FIRE.
  - ARM: on a valid poll with a match, hold_cnt+1. When hold_cnt reaches HOLD_POLLS -> FIRE. On a valid poll without a match -> IDLE, hold_cnt=0.
  - FIRE: asserts its request output for exactly one cycle, then -> RELEASE.
  - RELEASE: stays here until a valid poll without a match -> IDLE. Holding a combo therefore never re-fires.
- hold_cnt is 8 bits and saturating; it never wraps.
- use_igr_i low: both FSMs forced to IDLE and hold counters cleared; request outputs stay 0. Button edge flags (btn_state_o, btn_pressed_o, btn_update_o) still update.
- Same-poll conflict: if both FSMs would enter FIRE on the same poll, the reset FSM fires. The OSD FSM goes to RELEASE without pulsing. Reset has priority.
- Watchdog counter: cleared on every valid strobe, otherwise increments.
  - At all-ones it saturates: ctrl_lost_o=1, btn_state_o=0, btn_pressed_o=0, both FSMs -> IDLE.
  - The next valid strobe clears ctrl_lost_o on the following edge.
- Watchdog expiry and a valid strobe in the same cycle: the strobe wins; the counter is cleared and the poll is processed normally.
- First poll after reset or after loss: the previous state is treated as 0, so every pressed button shows as an edge in btn_pressed_o.

## Timing
- All outputs are registered. Reset values are 0 for all outputs. After reset the watchdog counter is 0 and ctrl_lost_o stays 0 until the watchdog first saturates.
- CTRL_RST high on any edge: all FSMs -> IDLE, all counters cleared, outputs 0 on the next edge. This includes reset during FIRE; a request already in progress is dropped.
- Latency: btn_state_o, btn_pressed_o and btn_update_o update one cycle after ctrl_data_valid_i.
- igr_reset_o / igr_osd_o: high in the cycle two edges after the qualifying strobe (one edge into FIRE, one edge to register the output). Pulse width is exactly one cycle.
- Back-to-back strobes on consecutive cycles must be accepted, with no lost polls.
- Watchdog expiry: with TIMEOUT_W=20 it takes 2^20−1 cycles (≈262 ms at 4 MHz) of no strobes to set ctrl_lost_o.

## Configuration
- IGR_OSD_COMBO_EN defined: the OSD combo FSM and igr_osd_o are implemented as described above.
- IGR_OSD_COMBO_EN not defined:
  - The OSD FSM is not synthesised and igr_osd_o is tied to 0.
  - The reset FSM behaves exactly the same as in the enabled build.
  - The IGR_OSD_COMBO parameter is accepted but unused.

## Test plan
- Hold 16'h080F for 30 polls with use_igr_i=1 -> igr_reset_o pulses once, 2 cycles after the 30th strobe. Continue holding for 50 more polls -> no further pulse.
- Hold 16'h080F for 29 polls, then send one poll of 16'h0000, then 29 more polls of 16'h080F -> no pulse.
- Hold 16'h080F with use_igr_i=0 -> no pulse, while btn_pressed_o=16'h080F after the first poll.
- Combo 16'h080F plus an extra Du (16'h081F) for 40 polls -> no pulse. Then release and re-press 16'h080F for 30 polls -> exactly one pulse.
- Stop strobes for 2^20 cycles -> ctrl_lost_o=1 and btn_state_o=0. Then send one strobe with 16'h0001 -> ctrl_lost_o=0, btn_pressed_o=16'h0001.
- With IGR_OSD_COMBO_EN defined, hold 16'h8C40 for 30 polls -> igr_osd_o pulses once. Assert CTRL_RST in the FIRE cycle -> no pulse and all outputs 0.
